gpc_input_conditioner: RTL

GPC_INPUT_CONDITIONER -- requirements
Module: gpc_input_conditioner

---
 rtl/gpc_pkg.sv | 27 ++
 rtl/gpc_sync_filter.sv | 85 ++++++++
 rtl/gpc_input_conditioner.sv | 118 +++++++++++
 3 files changed

// File: rtl/gpc_pkg.sv
// Shared encodings and constants for the general-purpose counter input conditioner.
package gpc_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam logic [7:0] GLITCH_SAT = 8'd255;

  function automatic logic edge_qualifies(input edge_sel_e sel, input logic rise,
                                          input logic fall);
    logic q;
    q = 1'b0;
    case (sel)
      EDGE_NONE: q = 1'b0;
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/gpc_sync_filter.sv
// Synchroniser chain followed by a run-length debounce filter with a glitch strobe.
module gpc_sync_filter
  import gpc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              raw_i,
  input  logic [FILT_W-1:0] filter_len_i,
  output logic              level_o,
  output logic              glitch_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FILT_W:0]        r_run;
  logic                   r_level;
  logic                   r_accept;
  logic                   r_pend;

  logic                   w_synced;
  logic [FILT_W:0]        w_thresh;
  logic [FILT_W:0]        w_run_inc;
  logic                   w_ref;
  logic                   w_diff;
  logic [FILT_W:0]        w_run_nxt;
  logic                   w_accept_nxt;
  logic                   w_pend_nxt;
  logic                   w_level_nxt;
  logic                   w_glitch;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_thresh  = {1'b0, filter_len_i} + {{FILT_W{1'b0}}, 1'b1};
  assign w_run_inc = r_run + {{FILT_W{1'b0}}, 1'b1};
  // While an acceptance is pending, new differences are measured against the incoming level.
  assign w_ref     = r_accept ? r_pend : r_level;
  assign w_diff    = w_synced ^ w_ref;

  always_comb begin
    w_run_nxt    = r_run;
    w_accept_nxt = 1'b0;
    w_pend_nxt   = r_pend;
    w_level_nxt  = w_ref;
    w_glitch     = 1'b0;
    if (w_diff) begin
      if (w_run_inc >= w_thresh) begin
        w_accept_nxt = 1'b1;
        w_pend_nxt   = w_synced;
        w_run_nxt    = '0;
      end else begin
        w_run_nxt = w_run_inc;
      end
    end else begin
      w_glitch  = (r_run != '0);
      w_run_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run    <= '0;
      r_level  <= 1'b0;
      r_accept <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_run    <= w_run_nxt;
      r_level  <= w_level_nxt;
      r_accept <= w_accept_nxt;
      r_pend   <= w_pend_nxt;
    end
  end

  assign level_o  = r_level;
  assign glitch_o = w_glitch;

endmodule

// File: rtl/gpc_input_conditioner.sv
// Conditions the count/trigger and capture pins into one-cycle pulses for the counter core.
module gpc_input_conditioner
  import gpc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              raw_input_i,
  input  logic              raw_capture_i,
  input  logic [FILT_W-1:0] filter_len_i,
  input  logic [1:0]        edge_sel_i,
  input  logic [3:0]        prescale_i,
  output logic              count_pulse_o,
  output logic              capture_pulse_o,
  output logic              level_o,
  output logic [7:0]        glitch_cnt_o
);

  logic       w_level;
  logic       w_glitch;
  logic       w_cap_level;
  logic       w_cap_glitch;

  logic       r_level_prev;
  logic       r_cap_prev;
  logic [3:0] r_presc;
  logic       r_count_pulse;
  logic       r_capture_pulse;
  logic [7:0] r_glitch_cnt;

  logic       w_rise;
  logic       w_fall;
  logic       w_qual;
  logic [3:0] w_presc_nxt;
  logic       w_count_pulse_nxt;
  logic       w_capture_pulse_nxt;
  logic [7:0] w_glitch_cnt_nxt;

  gpc_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_input_filter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .raw_i        (raw_input_i),
    .filter_len_i (filter_len_i),
    .level_o      (w_level),
    .glitch_o     (w_glitch)
  );

  gpc_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_capture_filter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .raw_i        (raw_capture_i),
    .filter_len_i (filter_len_i),
    .level_o      (w_cap_level),
    .glitch_o     (w_cap_glitch)
  );

  assign w_rise = w_level & ~r_level_prev;
  assign w_fall = ~w_level & r_level_prev;
  assign w_qual = edge_qualifies(edge_sel_e'(edge_sel_i), w_rise, w_fall);

  always_comb begin
    w_presc_nxt         = r_presc;
    w_count_pulse_nxt   = 1'b0;
    w_capture_pulse_nxt = enable_i & w_cap_level & ~r_cap_prev;
    w_glitch_cnt_nxt    = r_glitch_cnt;
    if (!enable_i) begin
      w_presc_nxt = 4'd0;
    end else if (w_qual) begin
      // Using >= lets a lowered prescale wrap on the very next edge.
      if (r_presc >= prescale_i) begin
        w_count_pulse_nxt = 1'b1;
        w_presc_nxt       = 4'd0;
      end else begin
        w_presc_nxt = r_presc + 4'd1;
      end
    end
    if (w_glitch && (r_glitch_cnt != GLITCH_SAT)) begin
      w_glitch_cnt_nxt = r_glitch_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_level_prev    <= 1'b0;
      r_cap_prev      <= 1'b0;
      r_presc         <= 4'd0;
      r_count_pulse   <= 1'b0;
      r_capture_pulse <= 1'b0;
      r_glitch_cnt    <= 8'd0;
    end else begin
      r_level_prev    <= w_level;
      r_cap_prev      <= w_cap_level;
      r_presc         <= w_presc_nxt;
      r_count_pulse   <= w_count_pulse_nxt;
      r_capture_pulse <= w_capture_pulse_nxt;
      r_glitch_cnt    <= w_glitch_cnt_nxt;
    end
  end

  assign count_pulse_o   = r_count_pulse;
  assign capture_pulse_o = r_capture_pulse;
  assign level_o         = w_level;
  assign glitch_cnt_o    = r_glitch_cnt;

  // The capture channel's glitch strobe has no consumer.
  logic w_unused;
  assign w_unused = w_cap_glitch;

endmodule
